// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage of the single-issue CPU. It holds the program
// counter, presents it to the instruction memory, selects the next PC, and
// captures the returned instruction into the IF/ID pipeline register.
// Decode can stall the stage. A jump or taken branch flushes IF/ID.
// The stage also counts the instructions it retires into IF/ID.
//
// Parameters
//   RESET_PC      PC loaded on reset (word aligned)
//   NOP_INSTR     bubble instruction written into IF/ID on reset and flush
//
// Ports
//   clk             in   clock, all state updates on the rising edge
//   rst             in   synchronous active-high reset
//   imem_addr       out  byte address to instruction memory (mirrors pc)
//   imem_instr      in   instruction returned combinationally for imem_addr
//   stall           in   decode cannot accept; hold pc and IF/ID
//   branch_taken    in   redirect to branch_target
//   branch_target   in   branch destination (byte address)
//   jump            in   redirect to jump_target (beats branch_taken)
//   jump_target     in   jump destination (byte address)
//   instr_id        out  IF/ID instruction
//   pc_id           out  PC of instr_id
//   pc_plus4_id     out  pc_id + 4
//   valid_id        out  IF/ID holds a real fetched instruction
//   fetch_count     out  valid instructions loaded into IF/ID since reset
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] instr_id,
    output logic [31:0] pc_id,
    output logic [31:0] pc_plus4_id,
    output logic        valid_id,
    output logic [31:0] fetch_count
);

    // Action taken on the next edge, in priority order after reset.
    typedef enum logic [1:0] {
        ACT_JUMP    = 2'd0,
        ACT_BRANCH  = 2'd1,
        ACT_STALL   = 2'd2,
        ACT_ADVANCE = 2'd3
    } fetch_act_e;

    // Redirect targets lose their byte offset; there is no misalignment trap.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        word_align = addr & 32'hFFFF_FFFC;
    endfunction

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

    logic [31:0] pc_q,          pc_d;
    logic [31:0] instr_id_q,    instr_id_d;
    logic [31:0] pc_id_q,       pc_id_d;
    logic [31:0] pc_plus4_id_q, pc_plus4_id_d;
    logic        valid_id_q,    valid_id_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    fetch_act_e  act_s;
    logic [31:0] pc_plus4_s;

    // The memory path carries nothing but the pc register.
    assign imem_addr  = pc_q;
    assign pc_plus4_s = pc_q + 32'd4;

    // Priority decode of the per-edge action: jump > branch > stall > advance.
    always_comb begin
        act_s = ACT_ADVANCE;
        if (jump) begin
            act_s = ACT_JUMP;
        end else if (branch_taken) begin
            // A redirect overrides stall: the stalled decode slot is squashed.
            act_s = ACT_BRANCH;
        end else if (stall) begin
            act_s = ACT_STALL;
        end else begin
            act_s = ACT_ADVANCE;
        end
    end

    // Next-state values for pc, IF/ID and the fetch counter.
    always_comb begin
        pc_d          = pc_q;
        instr_id_d    = instr_id_q;
        pc_id_d       = pc_id_q;
        pc_plus4_id_d = pc_plus4_id_q;
        valid_id_d    = valid_id_q;
        fetch_count_d = fetch_count_q;

        case (act_s)
            ACT_JUMP: begin
                pc_d          = word_align(jump_target);
                instr_id_d    = NOP_INSTR;
                pc_id_d       = 32'h0000_0000;
                pc_plus4_id_d = 32'h0000_0000;
                valid_id_d    = 1'b0;
            end
            ACT_BRANCH: begin
                pc_d          = word_align(branch_target);
                instr_id_d    = NOP_INSTR;
                pc_id_d       = 32'h0000_0000;
                pc_plus4_id_d = 32'h0000_0000;
                valid_id_d    = 1'b0;
            end
            ACT_STALL: begin
                // Hold everything, including a bubble if the stage is empty.
                pc_d          = pc_q;
                instr_id_d    = instr_id_q;
                pc_id_d       = pc_id_q;
                pc_plus4_id_d = pc_plus4_id_q;
                valid_id_d    = valid_id_q;
            end
            ACT_ADVANCE: begin
                // Additions wrap at 2^32: pc FFFF_FFFC advances to 0.
                pc_d          = pc_plus4_s;
                instr_id_d    = imem_instr;
                pc_id_d       = pc_q;
                pc_plus4_id_d = pc_plus4_s;
                valid_id_d    = 1'b1;
                fetch_count_d = fetch_count_q + 32'd1;
            end
            default: begin
                // Unreachable encoding: park in a flushed, safe state.
                pc_d          = pc_q;
                instr_id_d    = NOP_INSTR;
                pc_id_d       = 32'h0000_0000;
                pc_plus4_id_d = 32'h0000_0000;
                valid_id_d    = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset that discards pending inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC_ALIGNED;
            instr_id_q    <= NOP_INSTR;
            pc_id_q       <= 32'h0000_0000;
            pc_plus4_id_q <= 32'h0000_0000;
            valid_id_q    <= 1'b0;
            fetch_count_q <= 32'h0000_0000;
        end else begin
            pc_q          <= pc_d;
            instr_id_q    <= instr_id_d;
            pc_id_q       <= pc_id_d;
            pc_plus4_id_q <= pc_plus4_id_d;
            valid_id_q    <= valid_id_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign instr_id    = instr_id_q;
    assign pc_id       = pc_id_q;
    assign pc_plus4_id = pc_plus4_id_q;
    assign valid_id    = valid_id_q;
    assign fetch_count = fetch_count_q;

endmodule
